timed_event_scheduler: RTL and testbench
========================================

// Module: timed_event_scheduler
// PURPOSE
//  Multi-channel, wrap-aware timestamp scheduler for the inband TX path. Each channel
//  accepts one timestamp through a valid/ready handshake, holds it, and compares it
//  every cycle against the free-running sample counter `now`. It pulses `fire` on the
//  exact cycle, or reports `late` when the target has already passed.
// PARAMETERS
//  TS_WIDTH    32  width of timestamps and of `now`; all arithmetic is modulo 2^TS_WIDTH
//  NUM_CH      4   number of independent channels (1..16)
//  HORIZON     2^(TS_WIDTH-1)-1  maximum accepted lead; a future lead above this is rejected
// PORTS
//  clock        in   1              system clock; all logic on the rising edge
//  reset        in   1              synchronous, active-high reset
//  now          in   TS_WIDTH       current sample-clock count; may wrap or jump
//  load_valid   in   NUM_CH         per-channel request to arm a timestamp
//  load_ready   out  NUM_CH         channel idle, can accept a load
//  load_ts      in   NUM_CH*TS_WIDTH  packed timestamps; ch i = [i*TS_WIDTH +: TS_WIDTH]
//  cancel       in   NUM_CH         drop the armed timestamp, no fire
//  fire         out  NUM_CH         1-cycle pulse: timestamp reached
//  late         out  NUM_CH         1-cycle pulse: timestamp in the past at evaluation
//  reject       out  NUM_CH         1-cycle pulse: lead > HORIZON, load discarded
//  armed        out  NUM_CH         channel holds a pending timestamp
// BEHAVIOUR
//  - diff = ts - now (mod 2^TS_WIDTH). diff==0 -> MATCH; diff[MSB]==1 -> PAST
//    (includes diff==2^(TS_WIDTH-1)); 1<=diff<=HORIZON -> FUTURE; else -> OUT_OF_RANGE.
//  - Reset: all channels IDLE; load_ready=all 1s; fire, late, reject, armed = 0.
//  - Per-channel FSM: IDLE, ARMED, FIRE. Outputs fire/late/reject are registered.
//  - IDLE: load_ready=1. Load accepted when load_valid&load_ready; classify against `now`
//    in the accept cycle: MATCH -> FIRE; FUTURE -> ARMED; PAST -> late pulse next
//    cycle, go IDLE; OUT_OF_RANGE -> reject pulse next cycle, go IDLE.
//  - ARMED: load_ready=0, armed=1. Each cycle classify stored ts: MATCH -> FIRE;
//    PAST (now jumped past ts) -> late pulse, IDLE; FUTURE/OUT_OF_RANGE -> stay.
//  - FIRE: fire=1 for exactly one cycle (cycle after the MATCH sample), then IDLE;
//    load_ready=0 during FIRE. Latency: match sample -> fire pulse = 1 cycle.
//  - cancel in ARMED -> IDLE next cycle with no fire/late, even if MATCH occurs that
//    cycle (cancel wins). cancel in IDLE or FIRE is ignored. cancel+load_valid in IDLE:
//    load wins.
//  - Wrap-around: ts=0x00000001, now=0xfffffffe -> FUTURE (diff=3); fire 1 cycle after
//    now==0x00000001.
//  - Channels are fully independent; simultaneous events on different channels allowed.
//  - reset asserted mid-operation: pending timestamps discarded, no pulses produced.
// CONFIGURATION
//  TIMED_LATE_FIRE_EN defined: a PAST classification (at load or in ARMED) pulses
//   both late and fire in the same cycle (packet still sent, flagged late).
//  TIMED_LATE_FIRE_EN undefined: PAST pulses late only; fire stays 0 (packet dropped).
// STRUCTURE
//  - Shared include time_cmp_defs.vh: FSM state encodings (IDLE/ARMED/FIRE), compare
//    class encodings (MATCH/FUTURE/PAST/OUT_OF_RANGE), and a diff-classify function.
//  - Sub-module ts_channel: one FSM + TS_WIDTH timestamp register + classifier;
//    top instantiates NUM_CH copies in a generate loop and packs/unpacks vectors.
// TESTING
//  1. ch0 load ts=0x3 at now=0x0, now +1/cycle -> armed=1, fire[0] one cycle after
//     now==0x3, then load_ready[0]=1; no late.
//  2. Wrap: load ts=0x1 at now=0xfffffffe -> fire after now==0x1; no late/reject.
//  3. Past: load ts=0x80000002 at now=0x0 -> late[0] next cycle; fire[0]=1 only with
//     TIMED_LATE_FIRE_EN; armed stays 0.
//  4. HORIZON=0x100: load ts=0x200 at now=0x0 -> reject pulse; ts=0x100 -> armed.
//  5. ch1 armed ts=0x10; cancel asserted while now==0x10 -> no fire, no late, IDLE.
//  6. All 4 channels armed to ts=0x20, reset pulsed at now=0x18 -> all outputs at reset
//     values, no pulses at now=0x20; reload afterwards works.

Source files
------------

// File: rtl/timed_event_scheduler_pkg.sv
// Shared definitions for the timed event scheduler: channel FSM states, compare
// classes and the timestamp-difference classifier.
package timed_event_scheduler_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } ch_state_e;

    typedef enum logic [1:0] {
        CMP_MATCH        = 2'd0,
        CMP_FUTURE       = 2'd1,
        CMP_PAST         = 2'd2,
        CMP_OUT_OF_RANGE = 2'd3
    } cmp_class_e;

    // diff = ts - now (modular); the MSB alone marks PAST, including the half-range point
    function automatic cmp_class_e classify(input logic is_zero, input logic is_neg,
                                            input logic within_horizon);
        if (is_zero)        return CMP_MATCH;
        if (is_neg)         return CMP_PAST;
        if (within_horizon) return CMP_FUTURE;
        return CMP_OUT_OF_RANGE;
    endfunction

endpackage

// File: rtl/timed_event_scheduler_ts_channel.sv
// One scheduler channel: holds a single timestamp and pulses fire/late/reject.
// TIMED_LATE_FIRE_EN: a PAST classification also pulses fire alongside late.
//
//  state    | meaning
//  ST_IDLE  | empty, load_ready=1, classifies incoming loads
//  ST_ARMED | timestamp held, compared against now every cycle
//  ST_FIRE  | fire pulse cycle, returns to ST_IDLE
module timed_event_scheduler_ts_channel
    import timed_event_scheduler_pkg::*;
#(
    parameter int                  TS_WIDTH = 32,
    parameter logic [TS_WIDTH-1:0] HORIZON  = {1'b0, {(TS_WIDTH-1){1'b1}}}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [TS_WIDTH-1:0] now,
    input  logic                load_valid,
    input  logic [TS_WIDTH-1:0] load_ts,
    input  logic                cancel,
    output logic                load_ready,
    output logic                fire,
    output logic                late,
    output logic                reject,
    output logic                armed
);

`ifdef TIMED_LATE_FIRE_EN
    localparam logic PAST_FIRES = 1'b1;
`else
    localparam logic PAST_FIRES = 1'b0;
`endif

    ch_state_e           state_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic                fire_q;
    logic                late_q;
    logic                reject_q;

    logic [TS_WIDTH-1:0] cmp_ts;
    logic [TS_WIDTH-1:0] diff;
    cmp_class_e          cls;

    // One comparator serves both the accept cycle and the armed wait
    assign cmp_ts = (state_q == ST_ARMED) ? ts_q : load_ts;
    assign diff   = cmp_ts - now;
    assign cls    = classify(diff == '0, diff[TS_WIDTH-1], diff <= HORIZON);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ts_q     <= '0;
            fire_q   <= 1'b0;
            late_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            fire_q   <= 1'b0;
            late_q   <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        case (cls)
                            CMP_MATCH: begin
                                state_q <= ST_FIRE;
                                fire_q  <= 1'b1;
                            end
                            CMP_FUTURE: begin
                                state_q <= ST_ARMED;
                                ts_q    <= load_ts;
                            end
                            CMP_PAST: begin
                                late_q <= 1'b1;
                                fire_q <= PAST_FIRES;
                            end
                            default: reject_q <= 1'b1;
                        endcase
                    end
                end
                ST_ARMED: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                    end else if (cls == CMP_MATCH) begin
                        state_q <= ST_FIRE;
                        fire_q  <= 1'b1;
                    end else if (cls == CMP_PAST) begin
                        state_q <= ST_IDLE;
                        late_q  <= 1'b1;
                        fire_q  <= PAST_FIRES;
                    end
                end
                ST_FIRE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign armed      = (state_q == ST_ARMED);
    assign fire       = fire_q;
    assign late       = late_q;
    assign reject     = reject_q;

endmodule

// File: rtl/timed_event_scheduler.sv
// Multi-channel wrap-aware timestamp scheduler; NUM_CH independent channels.
// TIMED_LATE_FIRE_EN is honoured inside each channel.
module timed_event_scheduler
    import timed_event_scheduler_pkg::*;
#(
    parameter int                  TS_WIDTH = 32,
    parameter int                  NUM_CH   = 4,
    parameter logic [TS_WIDTH-1:0] HORIZON  = {1'b0, {(TS_WIDTH-1){1'b1}}}
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [TS_WIDTH-1:0]        now,
    input  logic [NUM_CH-1:0]          load_valid,
    output logic [NUM_CH-1:0]          load_ready,
    input  logic [NUM_CH*TS_WIDTH-1:0] load_ts,
    input  logic [NUM_CH-1:0]          cancel,
    output logic [NUM_CH-1:0]          fire,
    output logic [NUM_CH-1:0]          late,
    output logic [NUM_CH-1:0]          reject,
    output logic [NUM_CH-1:0]          armed
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timed_event_scheduler_ts_channel #(
            .TS_WIDTH (TS_WIDTH),
            .HORIZON  (HORIZON)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .now        (now),
            .load_valid (load_valid[g]),
            .load_ts    (load_ts[g*TS_WIDTH +: TS_WIDTH]),
            .cancel     (cancel[g]),
            .load_ready (load_ready[g]),
            .fire       (fire[g]),
            .late       (late[g]),
            .reject     (reject[g]),
            .armed      (armed[g])
        );
    end

endmodule

// File: tb/tb_timed_event_scheduler.sv
// Self-checking bench for timed_event_scheduler (4 channels, 32-bit, horizon 0x100).
module tb_timed_event_scheduler;

    localparam int          NC = 4;
    localparam logic [31:0] HZ = 32'h100;
`ifdef TIMED_LATE_FIRE_EN
    localparam logic LF = 1'b1;
`else
    localparam logic LF = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [31:0]     now;
    logic [NC-1:0]   load_valid, cancel;
    logic [NC*32-1:0] load_ts;
    logic [NC-1:0]   load_ready, fire, late, reject, armed;

    timed_event_scheduler #(.TS_WIDTH(32), .NUM_CH(NC), .HORIZON(HZ)) dut (
        .clock(clock), .reset(reset), .now(now), .load_valid(load_valid),
        .load_ready(load_ready), .load_ts(load_ts), .cancel(cancel),
        .fire(fire), .late(late), .reject(reject), .armed(armed));

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending target per channel plus a "fire pulse in progress" flag
    bit          m_pend[NC];
    bit          m_firing[NC];
    logic [31:0] m_ts[NC];
    logic [NC-1:0] e_fire, e_late, e_rej;

    // 0 match, 1 future, 2 past, 3 out of range
    function automatic int rel(input logic [31:0] ts, input logic [31:0] nw);
        longint d;
        d = (longint'(ts) - longint'(nw)) & 64'hFFFF_FFFF;
        if (d == 0) return 0;
        if (d >= 64'h8000_0000) return 2;
        if (d <= longint'(HZ)) return 1;
        return 3;
    endfunction

    task automatic model_edge();
        logic [31:0] ts;
        int r;
        e_fire = '0; e_late = '0; e_rej = '0;
        for (int c = 0; c < NC; c++) begin
            ts = load_ts[c*32 +: 32];
            if (reset) begin
                m_pend[c] = 0; m_firing[c] = 0;
            end else if (m_firing[c]) begin
                m_firing[c] = 0;
            end else if (!m_pend[c]) begin
                if (load_valid[c]) begin
                    r = rel(ts, now);
                    if (r == 0) begin m_firing[c] = 1; e_fire[c] = 1; end
                    else if (r == 1) begin m_pend[c] = 1; m_ts[c] = ts; end
                    else if (r == 2) begin e_late[c] = 1; e_fire[c] = LF; end
                    else e_rej[c] = 1;
                end
            end else if (cancel[c]) begin
                m_pend[c] = 0;
            end else begin
                r = rel(m_ts[c], now);
                if (r == 0) begin m_pend[c] = 0; m_firing[c] = 1; e_fire[c] = 1; end
                else if (r == 2) begin m_pend[c] = 0; e_late[c] = 1; e_fire[c] = LF; end
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (now=%h t=%0t)", nm, act, exp, now, $time);
        end
    endtask

    task automatic cycle();
        logic [NC-1:0] e_arm, e_rdy;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        for (int c = 0; c < NC; c++) begin
            e_arm[c] = m_pend[c];
            e_rdy[c] = !m_pend[c] && !m_firing[c];
        end
        check("model_fire",   32'(fire),       32'(e_fire));
        check("model_late",   32'(late),       32'(e_late));
        check("model_reject", 32'(reject),     32'(e_rej));
        check("model_armed",  32'(armed),      32'(e_arm));
        check("model_ready",  32'(load_ready), 32'(e_rdy));
    endtask

    task automatic set_ts(input int ch, input logic [31:0] ts);
        load_ts[ch*32 +: 32] = ts;
    endtask

    typedef struct {
        logic [31:0] ts;
        logic [31:0] nw;
        logic f, l, r, a;
    } vec_t;
    vec_t tbl[10];

    int nf, nl, nr;
    logic [31:0] fire_at;
    logic [NC-1:0] any_pulse;

    initial begin
        reset = 1'b1; now = '0; load_valid = '0; cancel = '0; load_ts = '0;
        tbl[0] = '{32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0002, 32'h0000_0000, LF,   1'b1, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0200, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_0101, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{32'h0000_0000, 32'h8000_0000, LF,   1'b1, 1'b0, 1'b0};
        tbl[8] = '{32'h0000_0004, 32'h0000_0005, LF,   1'b1, 1'b0, 1'b0};
        tbl[9] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};

        cycle(); cycle();
        check("reset_ready", 32'(load_ready), 32'hF);
        check("reset_armed", 32'(armed), 32'h0);
        reset = 1'b0;
        cycle();

        // single-load classification vectors on ch0
        foreach (tbl[i]) begin
            now = tbl[i].nw; set_ts(0, tbl[i].ts); load_valid = 4'b0001;
            cycle();
            load_valid = '0;
            check("tbl_fire",   32'(fire[0]),   32'(tbl[i].f));
            check("tbl_late",   32'(late[0]),   32'(tbl[i].l));
            check("tbl_reject", 32'(reject[0]), 32'(tbl[i].r));
            check("tbl_armed",  32'(armed[0]),  32'(tbl[i].a));
            cancel = 4'b0001; cycle(); cancel = '0; cycle();
            check("tbl_idle", 32'(load_ready[0]), 32'h1);
        end

        // basic fire timing with now counting up
        now = 32'h0; set_ts(0, 32'h3); load_valid = 4'b0001;
        cycle(); load_valid = '0;
        check("t1_armed", 32'(armed[0]), 32'h1);
        nf = 0; nl = 0; fire_at = '1;
        for (int k = 1; k <= 6; k++) begin
            now = 32'(k); cycle();
            if (fire[0]) begin nf++; fire_at = now; end
            if (late[0]) nl++;
        end
        check("t1_fire_count", 32'(nf), 32'd1);
        check("t1_fire_at", fire_at, 32'h3);
        check("t1_late_count", 32'(nl), 32'd0);
        check("t1_ready_after", 32'(load_ready[0]), 32'h1);

        // wrap-around target
        now = 32'hFFFF_FFFE; set_ts(0, 32'h1); load_valid = 4'b0001;
        cycle(); load_valid = '0;
        nf = 0; nl = 0; nr = 0; fire_at = '1;
        for (int k = 0; k < 5; k++) begin
            now = now + 32'h1; cycle();
            if (fire[0]) begin nf++; fire_at = now; end
            if (late[0]) nl++;
            if (reject[0]) nr++;
        end
        check("t2_fire_count", 32'(nf), 32'd1);
        check("t2_fire_at", fire_at, 32'h1);
        check("t2_late_rej", 32'(nl + nr), 32'd0);

        // cancel wins over a same-cycle match on ch1
        now = 32'h0; set_ts(1, 32'h10); load_valid = 4'b0010;
        cycle(); load_valid = '0;
        now = 32'h10; cancel = 4'b0010;
        cycle(); cancel = '0;
        check("t5_fire", 32'(fire[1]), 32'h0);
        check("t5_late", 32'(late[1]), 32'h0);
        check("t5_armed", 32'(armed[1]), 32'h0);
        check("t5_ready", 32'(load_ready[1]), 32'h1);
        now = 32'h11; cycle();
        check("t5_no_late", 32'(late[1] | fire[1]), 32'h0);

        // reset mid-operation discards everything
        now = 32'h10;
        for (int c = 0; c < NC; c++) set_ts(c, 32'h20);
        load_valid = '1; cycle(); load_valid = '0;
        check("t6_all_armed", 32'(armed), 32'hF);
        now = 32'h18; reset = 1'b1; cycle(); reset = 1'b0;
        check("t6_rst_armed", 32'(armed), 32'h0);
        check("t6_rst_ready", 32'(load_ready), 32'hF);
        any_pulse = '0;
        for (int k = 32'h19; k <= 32'h22; k++) begin
            now = 32'(k); cycle();
            any_pulse = any_pulse | fire | late | reject;
        end
        check("t6_no_pulses", 32'(any_pulse), 32'h0);
        set_ts(2, 32'h30); load_valid = 4'b0100; cycle(); load_valid = '0;
        nf = 0; fire_at = '1;
        while (now < 32'h32) begin
            now = now + 32'h1; cycle();
            if (fire[2]) begin nf++; fire_at = now; end
        end
        check("t6_reload_fire", 32'(nf), 32'd1);
        check("t6_reload_at", fire_at, 32'h30);

        // randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) now = $urandom;
            else if (r < 10) now = now + 32'($urandom_range(2, 64));
            else now = now + 32'h1;
            load_valid = 4'($urandom_range(0, 15));
            for (int c = 0; c < NC; c++) begin
                int s;
                logic [31:0] lead;
                s = int'($urandom_range(0, 9));
                if (s < 6) lead = 32'($urandom_range(0, 64));
                else if (s < 8) lead = 32'($urandom_range(32'h80, 32'h180));
                else if (s == 8) lead = $urandom;
                else lead = 32'h0 - 32'($urandom_range(1, 8));
                set_ts(c, now + lead);
            end
            cancel = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0; load_valid = '0; cancel = '0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
